// File: rtl/disk_image_loader_if.sv
// ----------------------------------------------------------------------------
// disk_image_loader_if
//
// Bundles the two streaming sides of the disk image loader:
//   ioctl_*  : byte download stream from the ARM I/O block
//              (download flag, target index, byte offset, write strobe, data)
//   ram_*    : req/ack byte write port into SDRAM
//              (address, data, write request held until ack, ack)
//
// Modports:
//   slave  : the loader (sinks the ioctl stream, drives the RAM request)
//   master : the host/memory side (drives ioctl, answers with ram_ack)
// ----------------------------------------------------------------------------
interface disk_image_loader_if #(
    parameter int RAM_W = 25
);
    logic             ioctl_download;
    logic [4:0]       ioctl_index;
    logic [24:0]      ioctl_addr;
    logic             ioctl_wr;
    logic [7:0]       ioctl_dout;
    logic [RAM_W-1:0] ram_addr;
    logic [7:0]       ram_din;
    logic             ram_we;
    logic             ram_ack;

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_addr, ioctl_wr, ioctl_dout,
        input  ram_ack,
        output ram_addr, ram_din, ram_we
    );

    modport master (
        output ioctl_download, ioctl_index, ioctl_addr, ioctl_wr, ioctl_dout,
        output ram_ack,
        input  ram_addr, ram_din, ram_we
    );
endinterface

// File: rtl/disk_image_loader.sv
// ----------------------------------------------------------------------------
// disk_image_loader
//
// Captures ioctl disk image downloads into per-drive SDRAM windows and keeps
// per-drive image status for the wd1793 instances.  Slot s lives at
// RAM_BASE + (s << ADDR_W) and is selected by ioctl_index == BASE_INDEX + s.
// Bytes pass through a 2-entry buffer so the SDRAM req/ack port can stall
// without losing data; a slot only becomes ready once every buffered byte has
// been acknowledged by the RAM.
//
// Ports:
//   clk_sys, reset : system clock, synchronous active-high reset
//   bus            : ioctl download stream in, RAM req/ack write port out
//   eject          : per-slot one-cycle eject pulse
//   slot_ready     : per-slot image valid
//   slot_size      : packed per-slot image size (ADDR_W+1 bits each, slot 0 LSBs)
//   too_big        : sticky per-slot, a byte beyond the window was offered
//   drop_err       : sticky per-slot, a byte was lost to a full buffer
//   busy           : a download is being loaded, flushed or committed
// ----------------------------------------------------------------------------
module disk_image_loader #(
    parameter int               SLOTS      = 2,
    parameter int               ADDR_W     = 20,
    parameter int               RAM_W      = 25,
    parameter logic [RAM_W-1:0] RAM_BASE   = RAM_W'('h0200000),
    parameter int               BASE_INDEX = 1
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    disk_image_loader_if.slave        bus,
    input  logic [SLOTS-1:0]          eject,
    output logic [SLOTS-1:0]          slot_ready,
    output logic [SLOTS*(ADDR_W+1)-1:0] slot_size,
    output logic [SLOTS-1:0]          too_big,
    output logic [SLOTS-1:0]          drop_err,
    output logic                      busy
);

    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int SZ_W   = ADDR_W + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    // control state
    logic [1:0]        state_q,    state_d;
    logic              dl_prev_q,  dl_prev_d;
    logic [SLOT_W-1:0] active_q,   active_d;
    logic              wr_ptr_q,   wr_ptr_d;
    logic              rd_ptr_q,   rd_ptr_d;
    logic [1:0]        count_q,    count_d;
    logic              ram_we_q,   ram_we_d;
    logic [RAM_W-1:0]  ram_addr_q, ram_addr_d;
    logic [7:0]        ram_din_q,  ram_din_d;
    logic [SLOTS-1:0]  ready_q,    ready_d;
    logic [SZ_W-1:0]   size_q [SLOTS];
    logic [SZ_W-1:0]   size_d [SLOTS];
    logic [SLOTS-1:0]  too_big_q,  too_big_d;
    logic [SLOTS-1:0]  drop_err_q, drop_err_d;

    // data state (no reset needed: cleared at load start / only read when valid)
    logic [SZ_W-1:0]   hw_q,       hw_d;
    logic [ADDR_W-1:0] fifo_off_q [2];
    logic [ADDR_W-1:0] fifo_off_d [2];
    logic [7:0]        fifo_dat_q [2];
    logic [7:0]        fifo_dat_d [2];

    // decode of the incoming stream
    logic              dl_rise, dl_fall;
    logic [5:0]        idx_ext, idx_off;
    logic              idx_ok;
    logic [SLOT_W-1:0] idx_sel;
    logic              wr_far;
    logic [ADDR_W-1:0] wr_off;
    logic [SZ_W-1:0]   wr_off_p1;
    logic [RAM_W-1:0]  slot_base;
    logic              push, pop;
    logic [ADDR_W-1:0] head_off;
    logic [7:0]        head_dat;

    assign dl_rise   = bus.ioctl_download & ~dl_prev_q;
    assign dl_fall   = ~bus.ioctl_download & dl_prev_q;
    assign idx_ext   = {1'b0, bus.ioctl_index};
    assign idx_off   = idx_ext - 6'(BASE_INDEX);
    assign idx_ok    = (idx_ext >= 6'(BASE_INDEX)) && (idx_off < 6'(SLOTS));
    assign idx_sel   = idx_off[SLOT_W-1:0];
    assign wr_far    = (bus.ioctl_addr >> ADDR_W) != '0;
    assign wr_off    = bus.ioctl_addr[ADDR_W-1:0];
    assign wr_off_p1 = {1'b0, wr_off} + SZ_W'(1);
    assign slot_base = RAM_BASE + (RAM_W'(active_q) << ADDR_W);

    always_comb begin
        state_d    = state_q;
        dl_prev_d  = bus.ioctl_download;
        active_d   = active_q;
        hw_d       = hw_q;
        fifo_off_d = fifo_off_q;
        fifo_dat_d = fifo_dat_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ram_we_d   = ram_we_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ready_d    = ready_q;
        size_d     = size_q;
        too_big_d  = too_big_q;
        drop_err_d = drop_err_q;
        push       = 1'b0;
        pop        = 1'b0;
        head_off   = wr_off;
        head_dat   = bus.ioctl_dout;

        case (state_q)
            ST_IDLE: begin
                // Downloads to indices outside the slot range are ignored entirely.
                if (dl_rise && idx_ok) begin
                    active_d            = idx_sel;
                    ready_d[idx_sel]    = 1'b0;
                    size_d[idx_sel]     = '0;
                    too_big_d[idx_sel]  = 1'b0;
                    drop_err_d[idx_sel] = 1'b0;
                    hw_d                = '0;
                    state_d             = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (bus.ioctl_wr) begin
                    if (wr_far) begin
                        too_big_d[active_q] = 1'b1;
                    end else begin
                        // The size reflects every in-window offset offered,
                        // including bytes lost to a full buffer.
                        if (wr_off_p1 > hw_q) begin
                            hw_d = wr_off_p1;
                        end
                        if (count_q == 2'd2) begin
                            drop_err_d[active_q] = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
                    end
                end
                if (dl_fall) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if ((count_q == 2'd0) && !ram_we_q) begin
                    state_d = ST_COMMIT;
                end
            end
            default: begin // ST_COMMIT
                size_d[active_q]  = hw_q;
                ready_d[active_q] = (hw_q != '0) && !too_big_q[active_q] && !drop_err_q[active_q];
                state_d           = ST_IDLE;
            end
        endcase

        // Buffer write side
        if (push) begin
            fifo_off_d[wr_ptr_q] = wr_off;
            fifo_dat_d[wr_ptr_q] = bus.ioctl_dout;
            wr_ptr_d             = ~wr_ptr_q;
        end

        // RAM request. An entry stays in the buffer until acknowledged, so the
        // in-flight byte counts against the two entries. With an empty buffer
        // the incoming byte is launched straight away to save a cycle.
        if (count_q != 2'd0) begin
            head_off = fifo_off_q[rd_ptr_q];
            head_dat = fifo_dat_q[rd_ptr_q];
        end
        pop = ram_we_q && bus.ram_ack;
        if (pop) begin
            ram_we_d = 1'b0;
            rd_ptr_d = ~rd_ptr_q;
        end else if (!ram_we_q && ((count_q != 2'd0) || push)) begin
            ram_we_d   = 1'b1;
            ram_addr_d = slot_base + RAM_W'(head_off);
            ram_din_d  = head_dat;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // Eject is applied last so it overrides a same-cycle commit, but it
        // cannot touch the slot currently being written.
        for (int k = 0; k < SLOTS; k++) begin
            if (eject[k] && !((SLOT_W'(k) == active_q) &&
                              ((state_q == ST_LOAD) || (state_q == ST_FLUSH)))) begin
                ready_d[k] = 1'b0;
                size_d[k]  = '0;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            dl_prev_q  <= 1'b0;
            active_q   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ready_q    <= '0;
            too_big_q  <= '0;
            drop_err_q <= '0;
            for (int k = 0; k < SLOTS; k++) begin
                size_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            dl_prev_q  <= dl_prev_d;
            active_q   <= active_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ready_q    <= ready_d;
            too_big_q  <= too_big_d;
            drop_err_q <= drop_err_d;
            size_q     <= size_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        hw_q       <= hw_d;
        fifo_off_q <= fifo_off_d;
        fifo_dat_q <= fifo_dat_d;
    end

    assign bus.ram_we   = ram_we_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_din  = ram_din_q;
    assign slot_ready   = ready_q;
    assign too_big      = too_big_q;
    assign drop_err     = drop_err_q;
    assign busy         = (state_q != ST_IDLE);

    for (genvar g = 0; g < SLOTS; g++) begin : g_size
        assign slot_size[g*SZ_W +: SZ_W] = size_q[g];
    end

endmodule

// File: tb/tb_disk_image_loader.sv
module tb_disk_image_loader;

    localparam int SLOTS = 2;
    localparam int SZ_W  = 21;
    localparam logic [24:0] FAR = 25'h0100000;

    logic clk = 1'b0;
    logic reset;
    logic [SLOTS-1:0]      eject;
    logic [SLOTS-1:0]      slot_ready;
    logic [SLOTS*SZ_W-1:0] slot_size;
    logic [SLOTS-1:0]      too_big;
    logic [SLOTS-1:0]      drop_err;
    logic                  busy;

    always #5 clk = ~clk;

    disk_image_loader_if #(.RAM_W(25)) bus();

    disk_image_loader #(
        .SLOTS(SLOTS), .ADDR_W(20), .RAM_W(25),
        .RAM_BASE(25'h0200000), .BASE_INDEX(1)
    ) dut (
        .clk_sys   (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .eject     (eject),
        .slot_ready(slot_ready),
        .slot_size (slot_size),
        .too_big   (too_big),
        .drop_err  (drop_err),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int ack_delay = 1;
    int rsp_cnt   = 0;

    // observed RAM writes
    logic [24:0] log_addr[$];
    logic [7:0]  log_dat[$];
    // reference model
    logic [24:0]     exp_addr[$];
    logic [7:0]      exp_dat[$];
    logic            exp_ready [SLOTS];
    logic [SZ_W-1:0] exp_size  [SLOTS];
    logic            exp_tb    [SLOTS];
    logic            exp_de    [SLOTS];
    // stimulus for the next download
    logic [24:0] st_off[$];
    logic [7:0]  st_dat[$];

    // SDRAM responder: ack after ack_delay waiting cycles, logs accepted writes
    initial begin
        bus.ram_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                bus.ram_ack = 1'b0;
                rsp_cnt = 0;
            end else if (bus.ram_ack) begin
                bus.ram_ack = 1'b0;
            end else if (bus.ram_we) begin
                rsp_cnt++;
                if (rsp_cnt > ack_delay) begin
                    bus.ram_ack = 1'b1;
                    rsp_cnt = 0;
                    log_addr.push_back(bus.ram_addr);
                    log_dat.push_back(bus.ram_din);
                end
            end
        end
    end

    function automatic logic [SLOTS*(SZ_W+3)-1:0] exp_status();
        logic [SLOTS-1:0] r, t, d;
        logic [SLOTS*SZ_W-1:0] sz;
        for (int k = 0; k < SLOTS; k++) begin
            r[k] = exp_ready[k];
            t[k] = exp_tb[k];
            d[k] = exp_de[k];
            sz[k*SZ_W +: SZ_W] = exp_size[k];
        end
        return {r, sz, t, d};
    endfunction

    function automatic bit logs_equal();
        if (log_addr.size() != exp_addr.size()) return 1'b0;
        foreach (exp_addr[i])
            if (log_addr[i] !== exp_addr[i] || log_dat[i] !== exp_dat[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [24:0] first_or_zero(input logic [24:0] q[$]);
        return (q.size() > 0) ? q[0] : 25'h0;
    endfunction

    // Reference: what a download of st_off/st_dat should produce when no byte
    // is lost to backpressure.
    task automatic model_download(input logic [4:0] idx, input logic [SLOTS-1:0] ej);
        int s;
        logic [SZ_W-1:0] hw;
        logic [SLOTS-1:0] e;
        e = ej;
        s = int'(idx) - 1;
        if (s >= 0 && s < SLOTS) begin
            e[s] = 1'b0;
            exp_tb[s] = 1'b0;
            exp_de[s] = 1'b0;
            hw = '0;
            foreach (st_off[i]) begin
                if (st_off[i] >= FAR) exp_tb[s] = 1'b1;
                else begin
                    exp_addr.push_back(25'h0200000 + (25'(s) << 20) + st_off[i]);
                    exp_dat.push_back(st_dat[i]);
                    if (21'(st_off[i]) + 21'd1 > hw) hw = 21'(st_off[i]) + 21'd1;
                end
            end
            exp_size[s]  = hw;
            exp_ready[s] = (hw != 0) && !exp_tb[s] && !exp_de[s];
        end
        for (int k = 0; k < SLOTS; k++)
            if (e[k]) begin exp_ready[k] = 1'b0; exp_size[k] = '0; end
    endtask

    task automatic run_download(input logic [4:0] idx, input int gap,
                                input logic [SLOTS-1:0] ej, input bit chk_lat);
        bit valid;
        int c;
        valid = (idx >= 5'd1) && (idx <= 5'(SLOTS));
        @(negedge clk);
        bus.ioctl_index = idx;
        bus.ioctl_download = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== valid) begin
            n_fail++;
            $display("FAIL busy_at_start idx=%0d: got %b want %b", idx, busy, valid);
        end
        foreach (st_off[i]) begin
            bus.ioctl_addr = st_off[i];
            bus.ioctl_dout = st_dat[i];
            bus.ioctl_wr = 1'b1;
            if (i == 0) eject = ej;
            @(negedge clk);
            bus.ioctl_wr = 1'b0;
            eject = '0;
            if (chk_lat) begin
                n_checks++;
                if (bus.ram_we !== (valid && st_off[i] < FAR)) begin
                    n_fail++;
                    $display("FAIL write_latency off=%h: ram_we got %b want %b",
                             st_off[i], bus.ram_we, valid && st_off[i] < FAR);
                end
            end
            repeat (gap) @(negedge clk);
        end
        bus.ioctl_download = 1'b0;
        c = 0;
        do begin @(negedge clk); c++; end while (busy && c < 300);
        n_checks++;
        if (busy) begin
            n_fail++;
            $display("FAIL idle_timeout idx=%0d: busy still %b after %0d cycles, want 0", idx, busy, c);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        eject = '0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index = '0;
        bus.ioctl_addr = '0;
        bus.ioctl_wr = 1'b0;
        bus.ioctl_dout = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.ram_we, bus.ram_addr, bus.ram_din, slot_ready, slot_size, too_big, drop_err, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b size=%h we=%b busy=%b want all 0",
                     slot_ready, slot_size, bus.ram_we, busy);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.ram_we, slot_ready, slot_size, busy} !== '0) begin
            n_fail++;
            $display("FAIL post_reset_idle: ready=%b we=%b busy=%b want 0", slot_ready, bus.ram_we, busy);
        end
        for (int k = 0; k < SLOTS; k++) begin
            exp_ready[k] = 0; exp_size[k] = '0; exp_tb[k] = 0; exp_de[k] = 0;
        end
    endtask

    task automatic test_slot0_load;
        st_off = '{25'h0, 25'h1, 25'h2, 25'h3};
        st_dat = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        ack_delay = 1;
        run_download(5'd1, 2, '0, 1'b1);
        model_download(5'd1, '0);
        n_checks++;
        if (!logs_equal() || log_addr[0] !== 25'h0200000 || log_addr[3] !== 25'h0200003) begin
            n_fail++;
            $display("FAIL slot0_writes: got %0d writes first %h, want 4 first 0200000",
                     log_addr.size(), first_or_zero(log_addr));
        end
        n_checks++;
        if (slot_ready !== 2'b01 || slot_size[SZ_W-1:0] !== 21'd4) begin
            n_fail++;
            $display("FAIL slot0_ready_size: ready=%b size0=%0d want 01 / 4", slot_ready, slot_size[SZ_W-1:0]);
        end
        n_checks++;
        if ({slot_ready, slot_size, too_big, drop_err} !== exp_status()) begin
            n_fail++;
            $display("FAIL slot0_status: got %h want %h", {slot_ready, slot_size, too_big, drop_err}, exp_status());
        end
        log_addr.delete(); log_dat.delete(); exp_addr.delete(); exp_dat.delete();
    endtask

    task automatic test_oversize;
        st_off = '{FAR, 25'h10};
        st_dat = '{8'h55, 8'h66};
        run_download(5'd2, 2, '0, 1'b1);
        model_download(5'd2, '0);
        n_checks++;
        if (log_addr.size() != 1 || log_addr[0] !== 25'h0300010 || log_dat[0] !== 8'h66) begin
            n_fail++;
            $display("FAIL oversize_writes: got %0d writes first %h, want 1 at 0300010",
                     log_addr.size(), first_or_zero(log_addr));
        end
        n_checks++;
        if (too_big[1] !== 1'b1 || slot_ready[1] !== 1'b0 || slot_size[2*SZ_W-1:SZ_W] !== 21'h11) begin
            n_fail++;
            $display("FAIL oversize_status: too_big=%b ready=%b size1=%h want 1/0/11",
                     too_big[1], slot_ready[1], slot_size[2*SZ_W-1:SZ_W]);
        end
        n_checks++;
        if ({slot_ready, slot_size, too_big, drop_err} !== exp_status()) begin
            n_fail++;
            $display("FAIL oversize_model: got %h want %h", {slot_ready, slot_size, too_big, drop_err}, exp_status());
        end
        log_addr.delete(); log_dat.delete(); exp_addr.delete(); exp_dat.delete();
    endtask

    task automatic test_backpressure;
        st_off = '{25'h0, 25'h1, 25'h2};
        st_dat = '{8'($urandom), 8'($urandom), 8'($urandom)};
        ack_delay = 10;
        run_download(5'd1, 0, '0, 1'b0);
        ack_delay = 1;
        // two entries of buffering: the third back-to-back byte is lost
        exp_addr.push_back(25'h0200000); exp_dat.push_back(st_dat[0]);
        exp_addr.push_back(25'h0200001); exp_dat.push_back(st_dat[1]);
        exp_tb[0] = 0; exp_de[0] = 1; exp_size[0] = 21'd3; exp_ready[0] = 0;
        n_checks++;
        if (!logs_equal()) begin
            n_fail++;
            $display("FAIL backpressure_writes: got %0d writes first %h, want 2 first 0200000",
                     log_addr.size(), first_or_zero(log_addr));
        end
        n_checks++;
        if (drop_err[0] !== 1'b1 || slot_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_flags: drop_err=%b ready=%b want 1/0", drop_err[0], slot_ready[0]);
        end
        n_checks++;
        if ({slot_ready, slot_size, too_big, drop_err} !== exp_status()) begin
            n_fail++;
            $display("FAIL backpressure_status: got %h want %h", {slot_ready, slot_size, too_big, drop_err}, exp_status());
        end
        log_addr.delete(); log_dat.delete(); exp_addr.delete(); exp_dat.delete();
    endtask

    task automatic test_unknown_index;
        st_off.delete(); st_dat.delete();
        for (int i = 0; i < 8; i++) begin
            st_off.push_back(25'(i));
            st_dat.push_back(8'($urandom));
        end
        run_download(5'd0, 1, '0, 1'b1);
        model_download(5'd0, '0);
        n_checks++;
        if (log_addr.size() != 0) begin
            n_fail++;
            $display("FAIL unknown_index_writes: got %0d writes want 0", log_addr.size());
        end
        n_checks++;
        if ({slot_ready, slot_size, too_big, drop_err} !== exp_status()) begin
            n_fail++;
            $display("FAIL unknown_index_status: got %h want %h", {slot_ready, slot_size, too_big, drop_err}, exp_status());
        end
        log_addr.delete(); log_dat.delete(); exp_addr.delete(); exp_dat.delete();
    endtask

    task automatic test_eject;
        st_off = '{25'h0, 25'h1, 25'h2, 25'h3};
        st_dat = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_download(5'd1, 2, '0, 1'b0);
        model_download(5'd1, '0);
        @(negedge clk);
        eject = 2'b01;
        @(negedge clk);
        eject = '0;
        exp_ready[0] = 0; exp_size[0] = '0;
        n_checks++;
        if (slot_ready[0] !== 1'b0 || slot_size[SZ_W-1:0] !== 21'd0) begin
            n_fail++;
            $display("FAIL eject_idle: ready0=%b size0=%0d want 0/0", slot_ready[0], slot_size[SZ_W-1:0]);
        end
        // eject of the slot being loaded is ignored
        run_download(5'd1, 2, 2'b01, 1'b1);
        model_download(5'd1, 2'b01);
        n_checks++;
        if (slot_ready[0] !== 1'b1 || slot_size[SZ_W-1:0] !== 21'd4) begin
            n_fail++;
            $display("FAIL eject_during_load: ready0=%b size0=%0d want 1/4", slot_ready[0], slot_size[SZ_W-1:0]);
        end
        n_checks++;
        if ({slot_ready, slot_size, too_big, drop_err} !== exp_status() || !logs_equal()) begin
            n_fail++;
            $display("FAIL eject_status: got %h want %h", {slot_ready, slot_size, too_big, drop_err}, exp_status());
        end
        log_addr.delete(); log_dat.delete(); exp_addr.delete(); exp_dat.delete();
    endtask

    task automatic test_reset_mid_load;
        ack_delay = 10;
        @(negedge clk);
        bus.ioctl_index = 5'd1;
        bus.ioctl_download = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            bus.ioctl_addr = 25'(i);
            bus.ioctl_dout = 8'($urandom);
            bus.ioctl_wr = 1'b1;
            @(negedge clk);
        end
        bus.ioctl_wr = 1'b0;
        n_checks++;
        if (bus.ram_we !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_load_we: ram_we=%b want 1", bus.ram_we);
        end
        reset = 1'b1;
        bus.ioctl_download = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.ram_we, bus.ram_addr, bus.ram_din, slot_ready, slot_size, too_big, drop_err, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_load: we=%b ready=%b size=%h busy=%b want all 0",
                     bus.ram_we, slot_ready, slot_size, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.ram_we !== 1'b0 || busy !== 1'b0 || slot_ready !== '0) begin
            n_fail++;
            $display("FAIL after_abort: we=%b busy=%b ready=%b want 0/0/0", bus.ram_we, busy, slot_ready);
        end
        for (int k = 0; k < SLOTS; k++) begin
            exp_ready[k] = 0; exp_size[k] = '0; exp_tb[k] = 0; exp_de[k] = 0;
        end
        ack_delay = 1;
        log_addr.delete(); log_dat.delete(); exp_addr.delete(); exp_dat.delete();
    endtask

    task automatic test_random;
        logic [4:0] idx;
        logic [SLOTS-1:0] ej;
        int n;
        for (int it = 0; it < 14; it++) begin
            if ($urandom_range(0, 4) == 0)
                idx = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(3, 31));
            else
                idx = 5'($urandom_range(1, SLOTS));
            n = $urandom_range(1, 6);
            st_off.delete(); st_dat.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) st_off.push_back(25'($urandom_range(32'h100000, 32'h1FFFFFF)));
                else st_off.push_back(25'($urandom_range(0, 300)));
                st_dat.push_back(8'($urandom));
            end
            ej = ($urandom_range(0, 3) == 0) ? SLOTS'($urandom_range(1, 3)) : '0;
            ack_delay = $urandom_range(0, 1);
            run_download(idx, $urandom_range(2, 4), ej, 1'b1);
            model_download(idx, ej);
            n_checks++;
            if (!logs_equal()) begin
                n_fail++;
                $display("FAIL random_writes it=%0d: got %0d writes first %h, want %0d first %h",
                         it, log_addr.size(), first_or_zero(log_addr), exp_addr.size(), first_or_zero(exp_addr));
            end
            n_checks++;
            if ({slot_ready, slot_size, too_big, drop_err} !== exp_status()) begin
                n_fail++;
                $display("FAIL random_status it=%0d: got %h want %h",
                         it, {slot_ready, slot_size, too_big, drop_err}, exp_status());
            end
            log_addr.delete(); log_dat.delete(); exp_addr.delete(); exp_dat.delete();
            if ($urandom_range(0, 4) == 0) begin
                ej = SLOTS'($urandom_range(1, 3));
                eject = ej;
                @(negedge clk);
                eject = '0;
                for (int k = 0; k < SLOTS; k++)
                    if (ej[k]) begin exp_ready[k] = 0; exp_size[k] = '0; end
                n_checks++;
                if ({slot_ready, slot_size, too_big, drop_err} !== exp_status()) begin
                    n_fail++;
                    $display("FAIL random_eject it=%0d: got %h want %h",
                             it, {slot_ready, slot_size, too_big, drop_err}, exp_status());
                end
            end
        end
        ack_delay = 1;
    endtask

    initial begin
        test_reset();
        test_slot0_load();
        test_oversize();
        test_backpressure();
        test_unknown_index();
        test_eject();
        test_reset_mid_load();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/disk_image_loader.md
Name: disk_image_loader

Overview:
- Parametrised multi-drive successor to the single-drive image capture on the FDC path.
- Takes the ioctl download stream from the ARM I/O block and writes disk images into per-drive windows of SDRAM through a req/ack write port.
- Tracks per-drive image size, ready, oversize and drop status for the wd1793 instances.
- Supports N drives, a 2-entry write buffer, eject, and guarded commit of ready only after all writes drain.

Parameters:
- SLOTS, 2, number of drive image slots (1..4).
- ADDR_W, 20, per-slot offset width; maximum image size is 2^ADDR_W bytes.
- RAM_W, 25, RAM address width.
- RAM_BASE, 25'h0200000, RAM address of slot 0; slot s starts at RAM_BASE + (s << ADDR_W).
- BASE_INDEX, 1, ioctl_index value that selects slot 0; slot s is selected by BASE_INDEX+s.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- ioctl_download  in  1  download in progress
- ioctl_index  in  5  download target index
- ioctl_addr  in  25  byte offset of current ioctl_wr
- ioctl_wr  in  1  one-cycle byte strobe
- ioctl_dout  in  8  byte data
- eject  in  SLOTS  per-slot one-cycle eject pulse
- ram_addr  out  RAM_W  write address
- ram_din  out  8  write data
- ram_we  out  1  write request, held until ram_ack
- ram_ack  in  1  write accepted this cycle
- slot_ready  out  SLOTS  image valid
- slot_size  out  SLOTS*(ADDR_W+1)  packed image sizes, slot 0 in the LSBs
- too_big  out  SLOTS  sticky: write with offset >= 2^ADDR_W seen
- drop_err  out  SLOTS  sticky: write lost because the buffer was full
- busy  out  1  state != IDLE

Behaviour:
- Reset, synchronous, highest priority:
  - All outputs are 0 and the FIFO is emptied.
  - Reset during LOAD or FLUSH aborts immediately: ram_we drops the next cycle and the slot stays not ready.
- The state register is 2 bits: IDLE, LOAD, FLUSH, COMMIT.
- IDLE:
  - On a rising edge of ioctl_download, the target slot is s = ioctl_index - BASE_INDEX.
  - If s < SLOTS: latch s as active, clear slot_ready[s], slot_size[s], too_big[s], drop_err[s] and the high-water register, then go to LOAD.
  - Any other index means the whole download is ignored and no RAM writes occur.
- LOAD:
  - If ioctl_wr is high and ioctl_addr >= 2^ADDR_W: drop the byte and set too_big[s].
  - Otherwise push {offset, data} into the 2-entry FIFO and set high-water = max(high-water, offset+1), computed at ADDR_W+1 bits.
  - If the FIFO is full, no push happens: drop_err[s] is set and high-water still updates.
  - On a falling edge of ioctl_download, go to FLUSH.
- FLUSH: when the FIFO is empty and ram_we is low, go to COMMIT.
- COMMIT, one cycle:
  - slot_size[s] = high-water.
  - slot_ready[s] = (high-water != 0) & ~too_big[s] & ~drop_err[s].
  - Then go to IDLE.
- RAM port:
  - When the FIFO is non-empty and ram_we is low, ram_we rises the next cycle with ram_addr = RAM_BASE + (s << ADDR_W) + offset and data from the FIFO head.
  - ram_we and ram_addr/ram_din stay stable until ram_ack is sampled high. That entry pops; ram_we is low the following cycle, giving a minimum 1-cycle gap.
  - An ioctl_wr accepted in cycle n gives ram_we high at n+1 when the FIFO was empty.
  - A push and a pop in the same cycle are both performed and the count is unchanged.
- Eject:
  - eject[k] clears slot_ready[k] and slot_size[k] next cycle.
  - It is ignored for the active slot while in LOAD or FLUSH.
  - Eject in the same cycle as COMMIT on the same slot: eject wins.
- Edge detection uses the registered previous ioctl_download.
- A download start while not in IDLE is ignored; the current load finishes normally.

Test Plan:
- Slot 0 load: index 1, 4 writes at offsets 0..3 of 0xA0..0xA3, ram_ack one cycle after each ram_we -> RAM writes at 0x200000..0x200003 in order; slot_ready=01; slot_size[0]=4; busy low after COMMIT.
- Slot 1 oversize: index 2, one write at offset 0x100000 and one at 0x10 -> only 0x300010 written; too_big[1]=1; slot_ready[1]=0; slot_size[1]=0x11.
- Backpressure: ram_ack held low for 10 cycles, 3 back-to-back ioctl_wr -> first two written in order, third dropped; drop_err[0]=1; slot_ready[0]=0 after commit.
- Unknown index: index 0 download with 8 writes -> ram_we never asserts; slot_ready and slot_size unchanged.
- Eject: after a slot 0 load of size 4, pulse eject=01 -> next cycle slot_ready[0]=0 and slot_size[0]=0. eject[0] asserted during a slot 0 LOAD -> ignored; ready=1 at commit.
- Reset mid-load: reset after 2 of 5 writes while ram_we is high -> ram_we=0 next cycle; all outputs 0; state IDLE.
